// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//   VGA 640x480 timing generator for the pong display path. Runs on the 100 MHz
//   system clock and advances its pixel/line counters only on cycles where the
//   1-in-4 pixel enable (pix_tick) is high.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous reset, active low
//   pix_tick   in   pixel enable, one clk wide
//   hsync      out  horizontal sync, active level = SYNC_POL
//   vsync      out  vertical sync, active level = SYNC_POL
//   video_on   out  1 while the current pixel is inside the visible area
//   pixel_x    out  horizontal count, 0..H_TOTAL-1
//   pixel_y    out  vertical count, 0..V_TOTAL-1
//   line_end   out  combinational strobe on the last tick of each line
//   frame_end  out  combinational strobe on the last tick of each frame
//
// Build option
//   VGA_SYNC_OUTREG_EN : register hsync/vsync/video_on (1 clk behind pixel_x/y,
//                        video_on resets to 0). Undefined: combinational decode.
// -----------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_end,
  output logic       frame_end
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned CNT_W   = 10;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic             SYNC_IDLE  = ~SYNC_POL;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             v_last;
  logic             hs_act_c;
  logic             vs_act_c;
  logic             vis_c;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // Pixel/line counters; everything holds on cycles without a tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + CNT_W'(1);
        end
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  // Timing decode from the live counter values.
  always_comb begin
    hs_act_c = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    vs_act_c = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    vis_c    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  end

  assign pixel_x = h_cnt;
  assign pixel_y = v_cnt;

  // Strobes are gated by rst so nothing escapes while reset is held.
  assign line_end  = rst && pix_tick && h_last;
  assign frame_end = line_end && v_last;

`ifdef VGA_SYNC_OUTREG_EN
  // Registered pin drive: updates every clk, one clk behind the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync    <= SYNC_IDLE;
      vsync    <= SYNC_IDLE;
      video_on <= 1'b0;
    end else begin
      hsync    <= hs_act_c ? SYNC_POL : SYNC_IDLE;
      vsync    <= vs_act_c ? SYNC_POL : SYNC_IDLE;
      video_on <= vis_c;
    end
  end
`else
  assign hsync    = hs_act_c ? SYNC_POL : SYNC_IDLE;
  assign vsync    = vs_act_c ? SYNC_POL : SYNC_IDLE;
  assign video_on = vis_c;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
//   Self-checking bench for vga_sync_gen. A default-timing instance covers the
//   horizontal boundaries, pause and reset behaviour; a shrunken-timing instance
//   (15 x 13 frame) covers vertical sync and frame wrap within a short run.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

`ifdef VGA_SYNC_OUTREG_EN
  localparam int RST_VON = 0;
  localparam int LAT     = 1;
`else
  localparam int RST_VON = 1;
  localparam int LAT     = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_tick = 1'b0;
  logic       hsync, vsync, video_on, line_end, frame_end;
  logic [9:0] pixel_x, pixel_y;
  logic       hs_s, vs_s, von_s, le_s, fe_s;
  logic [9:0] x_s, y_s;

  int tests = 0;
  int fails = 0;

  // captured at the falling edge preceding each rising edge
  logic [9:0] cap_x, cap_y, cap_xs, cap_ys;
  logic       cap_hs, cap_vs, cap_von, cap_le, cap_fe;
  logic       cap_hss, cap_vss, cap_les, cap_fes;

  always #5 clk = ~clk;

  vga_sync_gen dut (
    .clk(clk), .rst(rst), .pix_tick(pix_tick),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .line_end(line_end), .frame_end(frame_end)
  );

  // 15-tick lines (hsync 10..12), 13-line frames (vsync 8..9)
  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_POL(1'b0)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_tick(pix_tick),
    .hsync(hs_s), .vsync(vs_s), .video_on(von_s),
    .pixel_x(x_s), .pixel_y(y_s),
    .line_end(le_s), .frame_end(fe_s)
  );

  typedef struct {
    int         ticks;
    int         gap;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
  } vec_t;

  vec_t vecs[12];
  vec_t sb[$];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // one clock: drive pix_tick, sample on falling edge, pass the rising edge
  task automatic step(input logic t);
    pix_tick = t;
    @(negedge clk);
    cap_x = pixel_x;  cap_y = pixel_y;  cap_hs = hsync;  cap_vs = vsync;
    cap_von = video_on; cap_le = line_end; cap_fe = frame_end;
    cap_xs = x_s; cap_ys = y_s; cap_hss = hs_s; cap_vss = vs_s;
    cap_les = le_s; cap_fes = fe_s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pix_tick = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, n_le, n_fe, first, second, hs_clk, vs_clk, le_cnt, cx, ch;
    vec_t e;

    //            ticks gap  x    y   hs  vs  von
    vecs[0]  = '{0,    4,   0,   0,  1,  1,  1};
    vecs[1]  = '{1,    4,   1,   0,  1,  1,  1};
    vecs[2]  = '{638,  4,   639, 0,  1,  1,  1};
    vecs[3]  = '{1,    4,   640, 0,  1,  1,  0};
    vecs[4]  = '{15,   4,   655, 0,  1,  1,  0};
    vecs[5]  = '{1,    4,   656, 0,  0,  1,  0};
    vecs[6]  = '{95,   4,   751, 0,  0,  1,  0};
    vecs[7]  = '{1,    4,   752, 0,  1,  1,  0};
    vecs[8]  = '{47,   4,   799, 0,  1,  1,  0};
    vecs[9]  = '{1,    4,   0,   1,  1,  1,  1};
    vecs[10] = '{8000, 1,   0,   11, 1,  1,  1};
    vecs[11] = '{300,  1,   300, 11, 1,  1,  1};

    rst = 1'b0;
    #1;
    chk("rst_x", int'(pixel_x), 0);
    chk("rst_y", int'(pixel_y), 0);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_video_on", int'(video_on), RST_VON);
    chk("rst_line_end", int'(line_end), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // table vectors: advance, settle two idle clocks, compare
    for (int i = 0; i < 12; i++) begin
      sb.push_back(vecs[i]);
      for (int k = 0; k < vecs[i].ticks; k++) begin
        step(1'b1);
        for (int g = 1; g < vecs[i].gap; g++) step(1'b0);
      end
      step(1'b0);
      step(1'b0);
      e = sb.pop_front();
      chk($sformatf("vec%0d_x", i), int'(cap_x), int'(e.x));
      chk($sformatf("vec%0d_y", i), int'(cap_y), int'(e.y));
      chk($sformatf("vec%0d_hsync", i), int'(cap_hs), int'(e.hs));
      chk($sformatf("vec%0d_vsync", i), int'(cap_vs), int'(e.vs));
      chk($sformatf("vec%0d_video_on", i), int'(cap_von), int'(e.von));
    end

    // pause at x=300: nothing moves, no strobes
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      step(1'b0);
      if (cap_x != 10'd300 || cap_le || cap_fe) bad++;
    end
    chk("pause_hold", bad, 0);
    chk("pause_x", int'(cap_x), 300);

    // reset mid-line at x=700 (inside hsync)
    for (int k = 0; k < 400; k++) step(1'b1);
    step(1'b0);
    step(1'b0);
    chk("pre_rst_x", int'(cap_x), 700);
    chk("pre_rst_hsync", int'(cap_hs), 0);
    pix_tick = 1'b1;
    rst = 1'b0;
    #2;
    chk("mid_rst_x", int'(pixel_x), 0);
    chk("mid_rst_y", int'(pixel_y), 0);
    chk("mid_rst_hsync", int'(hsync), 1);
    chk("mid_rst_vsync", int'(vsync), 1);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1);
      if (cap_x != 0 || cap_le || cap_fe || cap_les || cap_fes) bad++;
    end
    chk("rst_hold", bad, 0);
    rst = 1'b1;
    step(1'b1);
    step(1'b0);
    chk("post_rst_x", int'(cap_x), 1);
    chk("post_rst_y", int'(cap_y), 0);

    // two lines at 1-in-4 ticks: line_end period/width, hsync length
    do_reset();
    n_le = 0; first = -1; second = -1; hs_clk = 0; bad = 0;
    for (int c = 0; c < 6400; c++) begin
      step(c % 4 == 0);
      if (cap_le) begin
        n_le++;
        if (n_le == 1) first = c;
        else if (n_le == 2) second = c;
        if (cap_x != 10'd799 || cap_fe) bad++;
      end
      if (c < 3200 && !cap_hs) hs_clk++;
    end
    chk("le_count", n_le, 2);
    chk("le_first", first, 3196);
    chk("le_period", second - first, 3200);
    chk("le_state", bad, 0);
    chk("hsync_clks", hs_clk, 384);

    // small instance: two frames with pix_tick held high
    do_reset();
    n_fe = 0; first = -1; second = -1; vs_clk = 0; le_cnt = 0; bad = 0;
    for (int c = 0; c < 395; c++) begin
      step(1'b1);
      if (cap_fes) begin
        n_fe++;
        if (n_fe == 1) first = c;
        else if (n_fe == 2) second = c;
        if (cap_xs != 10'd14 || cap_ys != 10'd12) bad++;
      end
      if (c == 195 && (cap_xs != 0 || cap_ys != 0)) bad++;
      if (c < 195 && !cap_vss) vs_clk++;
      if (c < 195 && cap_les) le_cnt++;
    end
    chk("fe_count", n_fe, 2);
    chk("fe_first", first, 194);
    chk("fe_period", second - first, 195);
    chk("fe_wrap_state", bad, 0);
    chk("vsync_clks", vs_clk, 30);
    chk("small_le_count", le_cnt, 13);

    // small instance: reset while hsync and vsync both active at (11,8)
    do_reset();
    for (int k = 0; k < 131; k++) step(1'b1);
    step(1'b0);
    step(1'b0);
    chk("s_pre_rst_xy", int'(cap_xs) * 100 + int'(cap_ys), 1108);
    chk("s_pre_rst_sync", int'(cap_hss) * 2 + int'(cap_vss), 0);
    rst = 1'b0;
    #2;
    chk("s_rst_xy", int'(x_s) * 100 + int'(y_s), 0);
    chk("s_rst_sync", int'(hs_s) * 2 + int'(vs_s), 3);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // hsync assertion latency relative to pixel_x = 656, continuous ticks
    pix_tick = 1'b0;
    rst = 1'b0;
    #1;
    chk("lat_rst_video_on", int'(video_on), RST_VON);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cx = -1; ch = -1;
    for (int c = 0; c < 800; c++) begin
      step(1'b1);
      if (cap_x == 10'd656 && cx < 0) cx = c;
      if (!cap_hs && ch < 0) ch = c;
    end
    chk("lat_x656_clk", cx, 656);
    chk("lat_hsync", ch - cx, LAT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
